pipe_barrel_shifter: RTL and testbench
======================================

# pipe_barrel_shifter

Parametrised, pipelined barrel shifter: next generation of the 4-bit two-stage shifter, generalised to WIDTH bits with four shift modes. It registers one log2 stage per cycle and carries a valid/ready stream handshake with full backpressure. It sits in the datapath between a streaming producer and consumer; throughput is one word per clock when not stalled.

## Interface
- WIDTH, 8, data width; power of two, ≥ 2
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth; derived, not overridden
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  input word present
- o_ready  output  1  block can accept the input word this cycle
- i_mode  input  2  00 logical left (LSL), 01 logical right (LSR), 10 arithmetic right (ASR), 11 rotate left (ROL)
- i_shift  input  SHW  shift amount, 0..WIDTH-1
- i_data  input  WIDTH  operand
- o_valid  output  1  result present
- i_ready  input  1  consumer accepts the result this cycle
- o_data  output  WIDTH  result
- o_mode  output  2  mode that produced o_data

## Operation
- Transfer in: i_valid & o_ready at the clock edge. Transfer out: o_valid & i_ready at the clock edge.
- There are SHW register stages, stage k = 0..SHW-1. Each stage holds valid, mode, remaining shift bits, and data.
- Stage k applies a shift of 2^k when shift bit k is set. Otherwise it passes the data through unchanged.
  - LSL fills with 0.
  - LSR fills with 0.
  - ASR fills with the stage's data MSB. This equals the original sign, because ASR preserves the MSB.
  - ROL wraps the bits shifted out of the MSB back into the LSBs.
- Stage 0 captures i_data, i_mode and i_shift, shifted per i_shift[0]. The last stage drives o_valid, o_data and o_mode.
- Global stall: advance = ~o_valid | i_ready.
  - o_ready = advance. It is combinational from i_ready and o_valid, with no path from i_valid.
  - When advance = 0, every stage holds its contents. o_data and o_mode stay stable while o_valid = 1 and i_ready = 0.
  - When advance = 1, every stage loads from the previous one. Stage 0 loads valid = i_valid.
- Bubbles (valid = 0) propagate like words. Data registers of invalid stages are don't-care, but must not produce X on o_data after reset.
- Order is strictly preserved. There is no reordering, dropping or duplication.
- Shift by 0 returns i_data unchanged in all modes.
- i_shift is interpreted as unsigned. The full 0..WIDTH-1 range is legal, so no out-of-range case exists.

## Timing
- Reset, asynchronous on i_rst high:
  - all stage valids cleared; o_valid = 0
  - o_data = 0, o_mode = 0
  - o_ready = 1 once o_valid = 0
- Reset mid-operation discards all in-flight words. Nothing emerges after reset deasserts.
- Latency: a word accepted at edge N appears with o_valid = 1 after edge N+SHW-1, i.e. SHW cycles (3 for WIDTH = 8), when there is no stall.
- Throughput: 1 word/cycle with i_ready held high.
- A stall of S cycles delays every in-flight word by exactly S cycles.
- Simultaneous out-transfer and in-transfer in the same cycle is legal and required for full throughput.
- The first edge after reset release accepts input if i_valid = 1.
- WIDTH = 2 gives SHW = 1: a single stage with latency 1.

## Test plan
- WIDTH = 8, single word i_data = 0x96, i_shift = 3, i_ready = 1, one word per mode. Required o_data:
  - LSL → 0xB0
  - LSR → 0x12
  - ASR → 0xF2
  - ROL → 0xB4

  Each o_valid rises exactly 3 cycles after acceptance, and o_mode matches the input mode.
- Shift 0 and 7 sweep, i_data = 0x81:
  - shift 0 → 0x81 in all modes
  - shift 7: LSL → 0x80, LSR → 0x01, ASR → 0xFF, ROL → 0xC0
- Streaming: 16 back-to-back words with random data/shift/mode, i_ready = 1. Results come out on 16 consecutive cycles, each matching a reference model, in input order.
- Backpressure: stream 6 words, drop i_ready for 4 cycles while o_valid = 1. Required behaviour:
  - o_ready = 0 during the stall
  - o_data and o_mode stable during the stall
  - no word lost or duplicated
  - all 6 results correct and in order
- Reset mid-flight: accept 3 words, assert i_rst asynchronously between edges. Required behaviour:
  - o_valid and o_data go to 0 immediately
  - after release, no stale word appears
  - a new word 0x0F with LSL by 1 returns 0x1E at latency 3
- Parameter sweep: repeat the random stream test at WIDTH = 2, 4 and 32 (SHW = 1, 2, 5). Latency must equal SHW and all results must match the model.

Source files
------------

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: one log2 shift stage per register, four shift modes,
// valid/ready stream handshake with a global stall on output backpressure.
module pipe_barrel_shifter #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_mode,
  input  logic [SHW-1:0]   i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_mode
);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // One stage's conditional shift by 2^k in the given mode.
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] data,
    input logic [1:0]       mode,
    input int unsigned      k,
    input logic             en
  );
    logic [WIDTH-1:0] res;
    int unsigned      amt;
    amt = 32'd1 << k;
    if (en) begin
      case (mode)
        MODE_LSL: res = data << amt;
        MODE_LSR: res = data >> amt;
        MODE_ASR: res = $signed(data) >>> amt;
        MODE_ROL: res = (data << amt) | (data >> (32'(WIDTH) - amt));
        default:  res = data;
      endcase
    end else begin
      res = data;
    end
    return res;
  endfunction

  logic             valid_r      [SHW];
  logic [1:0]       mode_r       [SHW];
  logic [SHW-1:0]   rem_r        [SHW];
  logic [WIDTH-1:0] data_r       [SHW];

  logic             next_valid_s [SHW];
  logic [1:0]       next_mode_s  [SHW];
  logic [SHW-1:0]   next_rem_s   [SHW];
  logic [WIDTH-1:0] next_data_s  [SHW];

  logic             advance_s;
  logic             rem_unused_s;

  // A single advance signal stalls the whole pipe; it never depends on i_valid.
  assign advance_s = ~valid_r[SHW-1] | i_ready;
  assign o_ready   = advance_s;

  // Remaining shift bits are kept right-justified, so bit 0 is always the next stage's enable.
  assign rem_unused_s = ^rem_r[SHW-1];

  // Next-state values for every stage; bubbles carry zero data so o_data never goes X.
  always_comb begin
    next_valid_s[0] = i_valid;
    next_mode_s[0]  = i_mode;
    next_rem_s[0]   = i_shift >> 32'd1;
    if (i_valid) begin
      next_data_s[0] = shift_stage(i_data, i_mode, 32'd0, i_shift[0]);
    end else begin
      next_data_s[0] = {WIDTH{1'b0}};
    end
    for (int k = 1; k < SHW; k++) begin
      next_valid_s[k] = valid_r[k-1];
      next_mode_s[k]  = mode_r[k-1];
      next_rem_s[k]   = rem_r[k-1] >> 32'd1;
      if (valid_r[k-1]) begin
        next_data_s[k] = shift_stage(data_r[k-1], mode_r[k-1], 32'(k), rem_r[k-1][0]);
      end else begin
        next_data_s[k] = {WIDTH{1'b0}};
      end
    end
  end

  // Stage registers: cleared on reset, loaded together on advance, held otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < SHW; k++) begin
        valid_r[k] <= 1'b0;
        mode_r[k]  <= 2'b00;
        rem_r[k]   <= {SHW{1'b0}};
        data_r[k]  <= {WIDTH{1'b0}};
      end
    end else if (advance_s) begin
      for (int k = 0; k < SHW; k++) begin
        valid_r[k] <= next_valid_s[k];
        mode_r[k]  <= next_mode_s[k];
        rem_r[k]   <= next_rem_s[k];
        data_r[k]  <= next_data_s[k];
      end
    end
  end

  assign o_valid = valid_r[SHW-1];
  assign o_data  = data_r[SHW-1];
  assign o_mode  = mode_r[SHW-1];

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Bench for pipe_barrel_shifter: four instances (WIDTH 8, 2, 4, 32) checked every cycle
// against an arithmetic shift model with a scoreboard and exact latency accounting.
module tb_pipe_barrel_shifter;

  localparam int NB = 4;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  m;
    int          c;
    int          s;
  } item_t;

  logic        clk;
  logic        rst;
  logic        v_in   [NB];
  logic        rdy_in [NB];
  logic        ordy   [NB];
  logic        ov     [NB];
  logic [1:0]  md     [NB];
  logic [1:0]  omd    [NB];
  logic [4:0]  sh     [NB];
  logic [31:0] din    [NB];
  logic [31:0] dout   [NB];
  int          pend   [NB];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wof(input int b);
    case (b)
      0: return 8;
      1: return 2;
      2: return 4;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] wmask(input int b);
    longint unsigned m;
    m = (64'd1 << wof(b)) - 64'd1;
    return m[31:0];
  endfunction

  // Whole-word shift from the mode definitions, independent of any stage decomposition.
  function automatic logic [31:0] ref_shift(input logic [31:0] din_v, input int m, input int s, input int w);
    longint unsigned mask, d, r;
    mask = (64'd1 << w) - 64'd1;
    d = {32'd0, din_v} & mask;
    case (m)
      0: r = d << s;
      1: r = d >> s;
      2: begin
        r = d >> s;
        if (((d >> (w - 1)) & 64'd1) != 64'd0) r = r | (mask & ~(mask >> s));
      end
      3: r = (d << s) | (d >> (w - s));
      default: r = 64'd0;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NB; g++) begin : blk
    localparam int W = (g == 0) ? 8 : (g == 1) ? 2 : (g == 2) ? 4 : 32;
    localparam int S = $clog2(W);
    logic [W-1:0] q_s;
    logic [1:0]   m_s;
    logic         r_s;
    logic         v_s;

    pipe_barrel_shifter #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (v_in[g]),
      .o_ready (r_s),
      .i_mode  (md[g]),
      .i_shift (sh[g][S-1:0]),
      .i_data  (din[g][W-1:0]),
      .o_valid (v_s),
      .i_ready (rdy_in[g]),
      .o_data  (q_s),
      .o_mode  (m_s)
    );

    assign dout[g] = 32'(q_s);
    assign omd[g]  = m_s;
    assign ordy[g] = r_s;
    assign ov[g]   = v_s;

    // Scoreboard compare on the falling edge, where handshakes for the next rising edge are settled.
    initial begin
      item_t       sb[$];
      item_t       it;
      int          stalls;
      logic        prev_stall;
      logic [31:0] prev_d;
      logic [1:0]  prev_m;
      stalls = 0;
      prev_stall = 1'b0;
      prev_d = 32'd0;
      prev_m = 2'd0;
      pend[g] = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          sb.delete();
          prev_stall = 1'b0;
        end else begin
          checks++;
          if (ordy[g] !== (!ov[g] || rdy_in[g])) begin
            errors++;
            $display("FAIL o_ready w=%0d got=%b exp=%b", W, ordy[g], (!ov[g] || rdy_in[g]));
          end
          if (prev_stall) begin
            checks++;
            if (ov[g] !== 1'b1 || dout[g] !== prev_d || omd[g] !== prev_m) begin
              errors++;
              $display("FAIL stall_hold w=%0d got=%b/%h/%0d exp=1/%h/%0d", W, ov[g], dout[g], omd[g], prev_d, prev_m);
            end
          end
          if (ov[g] === 1'b1 && rdy_in[g]) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL unexpected_out w=%0d got=%h exp=none", W, dout[g]);
            end else begin
              it = sb.pop_front();
              if (dout[g] !== it.d || omd[g] !== it.m || cyc != it.c + S + (stalls - it.s)) begin
                errors++;
                $display("FAIL result w=%0d got=%h/m%0d/cyc%0d exp=%h/m%0d/cyc%0d", W, dout[g], omd[g], cyc,
                         it.d, it.m, it.c + S + (stalls - it.s));
              end
            end
          end
          if (v_in[g] && ordy[g] === 1'b1) begin
            it.d = ref_shift(din[g], int'(md[g]), int'(sh[g]) & (W - 1), W);
            it.m = md[g];
            it.c = cyc;
            it.s = stalls;
            sb.push_back(it);
          end
          prev_stall = (ov[g] === 1'b1) && !rdy_in[g];
          prev_d = dout[g];
          prev_m = omd[g];
          if (prev_stall) stalls++;
        end
        pend[g] = sb.size();
      end
    end
  end

  // Drives one word into instance b, then waits for its result and checks it against a literal.
  task automatic run_single(input int b, input int m, input int s, input logic [31:0] d,
                            input logic [31:0] exp, input int lat, input string name);
    int n;
    v_in[b] = 1'b1;
    md[b] = 2'(m);
    sh[b] = 5'(s);
    din[b] = d;
    @(posedge clk); #1;
    v_in[b] = 1'b0;
    n = 1;
    while (ov[b] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_data"}, dout[b], exp);
    chk({name, "_mode"}, {30'd0, omd[b]}, 32'(m));
    chk({name, "_lat"}, 32'(n), 32'(lat));
    @(posedge clk); #1;
  endtask

  // Presents a word and holds it until the block accepts it (bounded).
  task automatic send_hold(input int b, input int m, input int s, input logic [31:0] d);
    int   n;
    logic acc;
    v_in[b] = 1'b1;
    md[b] = 2'(m);
    sh[b] = 5'(s);
    din[b] = d;
    n = 0;
    do begin
      @(negedge clk);
      acc = ordy[b];
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    v_in[b] = 1'b0;
    chk("send_accept", {31'd0, acc}, 32'd1);
  endtask

  logic [7:0] e96 [4];
  logic [7:0] e81 [4];

  initial begin
    int n;
    e96 = '{8'hB0, 8'h12, 8'hF2, 8'hB4};
    e81 = '{8'h80, 8'h01, 8'hFF, 8'hC0};
    for (int b = 0; b < NB; b++) begin
      v_in[b] = 1'b0; rdy_in[b] = 1'b1; md[b] = 2'd0; sh[b] = 5'd0; din[b] = 32'd0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++) begin
      chk("rst_valid", {31'd0, ov[b]}, 32'd0);
      chk("rst_data", dout[b], 32'd0);
      chk("rst_mode", {30'd0, omd[b]}, 32'd0);
      chk("rst_ready", {31'd0, ordy[b]}, 32'd1);
    end
    rst = 1'b0;

    for (int m = 0; m < 4; m++) begin
      chk("model_96", ref_shift(32'h96, m, 3, 8), {24'd0, e96[m]});
      chk("model_81", ref_shift(32'h81, m, 7, 8), {24'd0, e81[m]});
      run_single(0, m, 3, 32'h96, {24'd0, e96[m]}, 3, "x96_s3");
      run_single(0, m, 0, 32'h81, 32'h81, 3, "x81_s0");
      run_single(0, m, 7, 32'h81, {24'd0, e81[m]}, 3, "x81_s7");
    end

    for (int i = 0; i < 16; i++) begin
      v_in[0] = 1'b1; md[0] = 2'($urandom); sh[0] = 5'($urandom_range(0, 7)); din[0] = {24'd0, 8'($urandom)};
      @(posedge clk); #1;
    end
    v_in[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("stream_drain", 32'(pend[0]), 32'd0);

    fork
      begin
        for (int i = 0; i < 6; i++) send_hold(0, $urandom_range(0, 3), $urandom_range(0, 7), {24'd0, 8'($urandom)});
      end
      begin
        n = 0;
        while (ov[0] !== 1'b1 && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        rdy_in[0] = 1'b0;
        #1;
        chk("bp_ready_low", {31'd0, ordy[0]}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        rdy_in[0] = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("bp_drain", 32'(pend[0]), 32'd0);

    for (int i = 0; i < 3; i++) begin
      v_in[0] = 1'b1; md[0] = 2'(i); sh[0] = 5'd0; din[0] = 32'hA5;
      @(posedge clk); #1;
    end
    v_in[0] = 1'b0;
    chk("pre_rst_valid", {31'd0, ov[0]}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, ov[0]}, 32'd0);
    chk("async_rst_data", dout[0], 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_stale", {31'd0, ov[0]}, 32'd0);
    end
    run_single(0, 0, 1, 32'h0F, 32'h1E, 3, "post_rst");

    for (int c = 0; c < 80; c++) begin
      for (int b = 0; b < NB; b++) begin
        v_in[b] = ($urandom % 4) != 0;
        md[b] = 2'($urandom);
        sh[b] = 5'($urandom_range(0, wof(b) - 1));
        din[b] = $urandom & wmask(b);
        rdy_in[b] = (c < 40) ? 1'b1 : (($urandom % 3) != 0);
      end
      @(posedge clk); #1;
    end
    for (int b = 0; b < NB; b++) begin
      v_in[b] = 1'b0;
      rdy_in[b] = 1'b1;
    end
    repeat (10) @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++) chk("sweep_drain", 32'(pend[b]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
